// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures the instruction word into the IF/ID register.
// Optional build macro FETCH_MISALIGN_TRAP_EN: misaligned redirects halt fetch and raise misalign_err.
module fetch_stage #(
    parameter int                    PC_WIDTH          = 32,
    parameter int                    INSTRUCTION_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC          = '0
) (
    input  logic                         clk,
    input  logic                         rstN,
    output logic [PC_WIDTH-1:0]          pc_out,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH-1:0]          redirect_pc,
    input  logic                         id_ready,
    output logic                         id_valid,
    output logic [INSTRUCTION_WIDTH-1:0] id_instr,
    output logic [PC_WIDTH-1:0]          id_pc,
    output logic [PC_WIDTH-1:0]          id_pc_plus4,
    output logic                         halted,
    output logic                         misalign_err
);

    // state      | meaning
    // ST_RUN     | fetching; IF/ID loads whenever it is empty or being consumed
    // ST_HALTED  | ebreak captured (or misaligned redirect trapped); PC frozen, no captures
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    localparam logic [INSTRUCTION_WIDTH-1:0] EBREAK     = INSTRUCTION_WIDTH'(32'h0010_0073);
    localparam logic [PC_WIDTH-1:0]          PC_STEP    = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0]          ALIGN_MASK = ~PC_WIDTH'(3);

    state_e                         state_q, state_d;
    logic [PC_WIDTH-1:0]            pc_q, pc_d;
    logic                           id_valid_q, id_valid_d;
    logic [INSTRUCTION_WIDTH-1:0]   id_instr_q, id_instr_d;
    logic [PC_WIDTH-1:0]            id_pc_q, id_pc_d;
    logic [PC_WIDTH-1:0]            id_pc_plus4_q, id_pc_plus4_d;
    logic                           advance;
    logic [PC_WIDTH-1:0]            pc_plus4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic                           misalign_err_q, misalign_err_d;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_err_d = 1'b0;
`endif
        advance  = (state_q == ST_RUN) && (!id_valid_q || id_ready);
        pc_plus4 = pc_q + PC_STEP;

        if (redirect_valid) begin
            // a redirect always flushes, whatever the handshake is doing
            id_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_d        = ST_HALTED;
                misalign_err_d = 1'b1;
            end else begin
                pc_d    = redirect_pc;
                state_d = ST_RUN;
            end
`else
            pc_d    = redirect_pc & ALIGN_MASK;
            state_d = ST_RUN;
`endif
        end else if (advance) begin
            id_valid_d    = 1'b1;
            id_instr_d    = instr_in;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            pc_d          = pc_plus4;
            if (instr_in == EBREAK) begin
                state_d = ST_HALTED;
            end
        end else if ((state_q == ST_HALTED) && id_ready) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= '0;
            id_pc_q       <= '0;
            id_pc_plus4_q <= PC_STEP;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            misalign_err_q <= 1'b0;
        end else begin
            misalign_err_q <= misalign_err_d;
        end
    end

    assign misalign_err = misalign_err_q;
`else
    assign misalign_err = 1'b0;
`endif

    assign pc_out      = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table, hand-written corner sequences, stream scoreboard.
module tb_fetch_stage;

    localparam logic [31:0] EBREAK    = 32'h0010_0073;
    localparam logic [31:0] EBRK_ADDR = 32'h0000_0010;

    logic        clk;
    logic        rstN;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        halted;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(
        .PC_WIDTH(32),
        .INSTRUCTION_WIDTH(32),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rstN(rstN),
        .pc_out(pc_out),
        .instr_in(instr_in),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .id_valid(id_valid),
        .id_instr(id_instr),
        .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4),
        .halted(halted),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory: address-tagged words, one ebreak at 0x10
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == EBRK_ADDR) return EBREAK;
        return {a[15:0], 16'h0013};
    endfunction

    assign instr_in = word_at(pc_out);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rdv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rdv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rdv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc_out;
        logic [31:0] e_id_pc;
        logic        e_halted;
        logic        e_mis;
    } vec_t;

    vec_t vecs[18];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    sb_t sb_q[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mpc;
        logic        mvalid;
        logic        rdy;
        sb_t         e;

        //            rdv  rpc           rdy  valid  pc_out        id_pc         halt  mis
        vecs[0]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h04,       32'h00,       1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h08,       32'h04,       1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0C,       32'h08,       1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0C,       32'h08,       1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0C,       32'h08,       1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0C,       32'h08,       1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       32'h0C,       1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h14,       32'h10,       1'b1, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h14,       32'h10,       1'b1, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h14,       32'h0,        1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h14,       32'h0,        1'b1, 1'b0};
        vecs[11] = '{1'b1, 32'h0,        1'b1, 1'b0, 32'h00,       32'h0,        1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h04,       32'h00,       1'b0, 1'b0};
        vecs[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h08,       32'h04,       1'b0, 1'b0};
        vecs[14] = '{1'b1, 32'h40,       1'b0, 1'b0, 32'h40,       32'h0,        1'b0, 1'b0};
        vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h44,       32'h40,       1'b0, 1'b0};
`ifdef FETCH_MISALIGN_TRAP_EN
        vecs[16] = '{1'b1, 32'h42,       1'b1, 1'b0, 32'h44,       32'h0,        1'b1, 1'b1};
        vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h44,       32'h0,        1'b1, 1'b0};
`else
        vecs[16] = '{1'b1, 32'h42,       1'b1, 1'b0, 32'h40,       32'h0,        1'b0, 1'b0};
        vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h44,       32'h40,       1'b0, 1'b0};
`endif

        rstN           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        @(posedge clk);
        #1;
        chk("reset.pc_out", pc_out, 32'h0);
        chk("reset.id_valid", {31'b0, id_valid}, 32'h0);
        chk("reset.id_instr", id_instr, 32'h0);
        chk("reset.id_pc", id_pc, 32'h0);
        chk("reset.id_pc_plus4", id_pc_plus4, 32'h4);
        chk("reset.halted", {31'b0, halted}, 32'h0);
        chk("reset.misalign_err", {31'b0, misalign_err}, 32'h0);
        rstN = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].rdv, vecs[i].rpc, vecs[i].rdy);
            chk($sformatf("vec%0d.id_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("vec%0d.pc_out", i), pc_out, vecs[i].e_pc_out);
            chk($sformatf("vec%0d.halted", i), {31'b0, halted}, {31'b0, vecs[i].e_halted});
            chk($sformatf("vec%0d.misalign_err", i), {31'b0, misalign_err}, {31'b0, vecs[i].e_mis});
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d.id_pc", i), id_pc, vecs[i].e_id_pc);
                chk($sformatf("vec%0d.id_instr", i), id_instr, word_at(vecs[i].e_id_pc));
                chk($sformatf("vec%0d.id_pc_plus4", i), id_pc_plus4, vecs[i].e_id_pc + 32'd4);
            end
        end

        // PC wrap at the top of the address space
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        chk("wrap.flush_valid", {31'b0, id_valid}, 32'h0);
        chk("wrap.target_pc", pc_out, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1);
        chk("wrap.id_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap.id_pc_plus4", id_pc_plus4, 32'h0);
        chk("wrap.pc_out", pc_out, 32'h0);
        chk("wrap.id_instr", id_instr, word_at(32'hFFFF_FFFC));

        // randomized back-pressure stream against a scoreboard
        step(1'b1, 32'h100, 1'b1);
        mpc    = 32'h100;
        mvalid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            chk($sformatf("sb%0d.pc_out", c), pc_out, mpc);
            chk($sformatf("sb%0d.id_valid", c), {31'b0, id_valid}, {31'b0, mvalid});
            rdy = ($urandom_range(0, 2) != 0);
            if (id_valid && rdy) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("sb%0d.unexpected_entry", c), id_pc, 32'hDEAD_BEEF);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("sb%0d.id_pc", c), id_pc, e.pc);
                    chk($sformatf("sb%0d.id_instr", c), id_instr, e.instr);
                end
            end
            if (!mvalid || rdy) begin
                sb_q.push_back('{pc: mpc, instr: word_at(mpc)});
                mpc    = mpc + 32'd4;
                mvalid = 1'b1;
            end
            step(1'b0, 32'h0, rdy);
        end
        chk("sb.residual_entries", sb_q.size(), 32'd1);

        // asynchronous reset mid-cycle
        @(negedge clk);
        rstN = 1'b0;
        #1;
        chk("async_rst.id_valid", {31'b0, id_valid}, 32'h0);
        chk("async_rst.pc_out", pc_out, 32'h0);
        chk("async_rst.id_pc_plus4", id_pc_plus4, 32'h4);
        @(negedge clk);
        rstN = 1'b1;
        step(1'b0, 32'h0, 1'b1);
        chk("post_rst.id_valid", {31'b0, id_valid}, 32'h1);
        chk("post_rst.id_pc", id_pc, 32'h0);
        chk("post_rst.pc_out", pc_out, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RISC-V core. Owns the program counter and drives it to the instruction memory's combinational read address. Captures the returned word into an IF/ID register that feeds decode through a valid/ready handshake. Handles pipeline stalls, branch/jump redirects with flush, and halts on `ebreak`.

## Interface
- `PC_WIDTH`, default 32: program counter width.
- `INSTRUCTION_WIDTH`, default 32: instruction word width.
- `RESET_PC`, default 0: PC value loaded at reset.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rstN`  input  1  reset, asynchronous, active-low.
- `pc_out`  output  PC_WIDTH  fetch address to instruction memory; equals the internal PC register.
- `instr_in`  input  INSTRUCTION_WIDTH  word returned combinationally by instruction memory for `pc_out`.
- `redirect_valid`  input  1  branch/jump taken this cycle.
- `redirect_pc`  input  PC_WIDTH  redirect target.
- `id_ready`  input  1  decode can accept the IF/ID contents this cycle.
- `id_valid`  output  1  IF/ID register holds a valid instruction.
- `id_instr`  output  INSTRUCTION_WIDTH  fetched instruction.
- `id_pc`  output  PC_WIDTH  address of `id_instr`.
- `id_pc_plus4`  output  PC_WIDTH  `id_pc + 4`, modulo 2^PC_WIDTH.
- `halted`  output  1  high while in the HALTED state.
- `misalign_err`  output  1  one-cycle pulse for a rejected misaligned redirect; tied 0 when the feature is compiled out.

## Operation
- States: RUN and HALTED. Reset enters RUN.
- Reset values: PC = `RESET_PC`; `id_valid`=0; `id_instr`=0; `id_pc`=0; `id_pc_plus4`=4; `halted`=0; `misalign_err`=0.
- Definition: `advance` = RUN && (!id_valid || id_ready).
- RUN with `advance`, no redirect:
  - IF/ID register loads `instr_in`, PC, and PC+4.
  - `id_valid` <= 1.
  - PC <= PC+4, wrapping modulo 2^PC_WIDTH; no overflow flag.
- RUN without `advance` (stall): PC and IF/ID register hold; `id_valid` stays 1.
- `id_valid`=1 && `id_ready`=1 consumes the entry in that cycle. If `advance` also holds, the next entry is loaded in the same edge, giving back-to-back throughput of one instruction per cycle.
- Redirect (any state, highest priority):
  - PC <= `redirect_pc`; `id_valid` <= 0 (flush); state <= RUN.
  - `instr_in` for the old PC is discarded.
  - A redirect coinciding with a stall or a consume still flushes.
- `ebreak` (`32'h00100073`) captured during an advance: loaded normally (`id_valid`=1), then state <= HALTED.
- HALTED:
  - PC frozen at the address after `ebreak`.
  - No further captures occur. The existing IF/ID entry stays until `id_ready` consumes it, then `id_valid` <= 0.
  - Leaves HALTED only by redirect or reset.
- Reset asserted mid-operation forces all reset values immediately and asynchronously. A pending handshake is lost.

## Timing
- `pc_out` is a register output. `instr_in` must be valid within the same cycle (asynchronous memory read).
- Fetch-to-decode latency: 1 cycle. The word at PC cycle N appears on `id_*` in cycle N+1.
- First `id_valid`=1 appears on the first rising edge after `rstN` deasserts, with `id_pc`=`RESET_PC`.
- Redirect penalty: the cycle after a redirect has `id_valid`=0 and `pc_out`=target. The target instruction is valid on `id_*` one cycle later.
- `halted` rises in the cycle after `ebreak` is captured, i.e. the same cycle `ebreak` appears on `id_instr`.
- `misalign_err` is registered and pulses for exactly 1 cycle after the offending redirect.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: a redirect with `redirect_pc[1:0]` != 0 is rejected.
  - PC unchanged; IF/ID flushed; state <= HALTED.
  - `misalign_err` pulses 1 cycle.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - `redirect_pc[1:0]` is forced to 00 and the redirect proceeds normally.
  - `misalign_err` is constant 0.

## Test plan
- Reset release, `RESET_PC`=0, `id_ready`=1, memory holds nop-like words -> `id_pc` sequence 0,4,8,C on consecutive cycles; `id_valid`=1 from the first edge.
- `id_ready`=0 for 3 cycles while `id_pc`=8 -> `id_pc`=8, `id_valid`=1 and `pc_out`=C held throughout; `id_pc`=C the cycle after `id_ready` returns to 1.
- Redirect to `0x40` while `id_pc`=4, coinciding with a stall -> next cycle `id_valid`=0 and `pc_out`=0x40; following cycle `id_pc`=0x40 with the word at 0x40.
- `ebreak` at 0x10 -> `id_instr`=00100073 and `halted`=1 in the same cycle; `pc_out` frozen at 0x14; after consume `id_valid`=0; a redirect to 0 resumes fetch with `halted`=0.
- PC at `0xFFFFFFFC` advancing -> `pc_out` wraps to 0, and `id_pc_plus4`=0 for the entry at `0xFFFFFFFC`.
- Redirect to `0x42`:
  - With `FETCH_MISALIGN_TRAP_EN`: `misalign_err` pulses 1 cycle, `halted`=1, PC unchanged.
  - Without it: `pc_out`=0x40, `misalign_err`=0.
